// File: rtl/aad_pkg.sv
// Shared constants, width helper and result record for the streaming 2x2 AAD pooling block.
package aad_pkg;

  localparam int AAD_DIV = 12;

  function automatic int sum_w(input int pix_w);
    return pix_w + 1;
  endfunction

  // Result record at the default 8-bit pixel width; the top builds its own copy sized by PIX_W.
  localparam int AAD_DEF_SUM_W = 9;

  typedef struct packed {
    logic [AAD_DEF_SUM_W-1:0] hor;
    logic [AAD_DEF_SUM_W-1:0] ver;
    logic [AAD_DEF_SUM_W-1:0] hor_div;
    logic [AAD_DEF_SUM_W-1:0] ver_div;
    logic                     last;
  } aad_res_t;

endpackage

// File: rtl/aad_absdiff.sv
// Unsigned absolute difference |a-b|; the result never wraps.
module aad_absdiff #(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0] a_i,
  input  logic [PIX_W-1:0] b_i,
  output logic [PIX_W-1:0] d_o
);

  assign d_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);

endmodule

// File: rtl/aad_pool_stream.sv
// Streaming 2x2 absolute-adjacent-difference pooling over raster pixels using a one-row pair buffer.
// Define AAD_DIV12_EN to produce floor(sum/12) on out_hor_div/out_ver_div; otherwise both read 0.
module aad_pool_stream
  import aad_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int COLS  = 8,
  parameter int ROWS  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pix,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W:0]   out_hor,
  output logic [PIX_W:0]   out_ver,
  output logic [PIX_W:0]   out_hor_div,
  output logic [PIX_W:0]   out_ver_div,
  output logic             out_last
);

  localparam int SW = sum_w(PIX_W);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int BE = COLS / 2;
  localparam int BW = (BE > 1) ? $clog2(BE) : 1;

  typedef struct packed {
    logic [SW-1:0] hor;
    logic [SW-1:0] ver;
    logic [SW-1:0] hor_div;
    logic [SW-1:0] ver_div;
    logic          last;
  } res_t;

  logic [CW-1:0]      col_q, col_d, cur_col;
  logic [RW-1:0]      row_q, row_d, cur_row;
  logic [PIX_W-1:0]   left_q, left_d;
  logic [2*PIX_W-1:0] pair_q [BE];
  logic [BW-1:0]      pair_idx;
  res_t               res_q, res_d;
  logic               valid_q, valid_d;
  logic               accept, win, buf_we;
  logic [PIX_W-1:0]   p00, p01, p10, p11;
  logic [PIX_W-1:0]   d_h0, d_h1, d_v0, d_v1;

  // Handshake: a pixel transfers when in_valid && in_ready, a result when out_valid && out_ready;
  // in_ready opens whenever the single output slot is empty or being drained this cycle.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // A start-of-frame pixel is position (0,0) no matter where the counters stand.
  assign cur_col  = in_sof ? '0 : col_q;
  assign cur_row  = in_sof ? '0 : row_q;
  assign pair_idx = BW'(cur_col >> 1);

  assign p00 = pair_q[pair_idx][2*PIX_W-1:PIX_W];
  assign p01 = pair_q[pair_idx][PIX_W-1:0];
  assign p10 = left_q;
  assign p11 = in_pix;

  assign win    = accept && cur_row[0] && cur_col[0];
  assign buf_we = accept && !cur_row[0] && cur_col[0];

  aad_absdiff #(.PIX_W(PIX_W)) u_h0 (.a_i(p00), .b_i(p01), .d_o(d_h0));
  aad_absdiff #(.PIX_W(PIX_W)) u_h1 (.a_i(p10), .b_i(p11), .d_o(d_h1));
  aad_absdiff #(.PIX_W(PIX_W)) u_v0 (.a_i(p00), .b_i(p10), .d_o(d_v0));
  aad_absdiff #(.PIX_W(PIX_W)) u_v1 (.a_i(p01), .b_i(p11), .d_o(d_v1));

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    left_d  = left_q;
    valid_d = valid_q;
    res_d   = res_q;

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      if (!cur_col[0]) begin
        left_d = in_pix;
      end
      if (cur_col == CW'(COLS - 1)) begin
        col_d = '0;
        row_d = (cur_row == RW'(ROWS - 1)) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end

    // A completing window reloads the slot even while the previous result is being drained.
    if (win) begin
      valid_d    = 1'b1;
      res_d.hor  = SW'(d_h0) + SW'(d_h1);
      res_d.ver  = SW'(d_v0) + SW'(d_v1);
      res_d.last = (cur_row == RW'(ROWS - 1)) && (cur_col == CW'(COLS - 1));
`ifdef AAD_DIV12_EN
      res_d.hor_div = SW'(32'(res_d.hor) / 32'(AAD_DIV));
      res_d.ver_div = SW'(32'(res_d.ver) / 32'(AAD_DIV));
`else
      res_d.hor_div = '0;
      res_d.ver_div = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      left_q  <= '0;
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      left_q  <= left_d;
      valid_q <= valid_d;
      res_q   <= res_d;
    end
  end

  // Pair buffer holds the top row of each window; its contents need no reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      pair_q[pair_idx] <= {left_q, in_pix};
    end
  end

  assign out_valid   = valid_q;
  assign out_hor     = res_q.hor;
  assign out_ver     = res_q.ver;
  assign out_hor_div = res_q.hor_div;
  assign out_ver_div = res_q.ver_div;
  assign out_last    = res_q.last;

endmodule
